// File: rtl/rep_pkg.sv
// Shared types for the repetition window detector: memory entry layout and
// the saturating per-entry count update.
package rep_pkg;

    // Widest tag/count any instance may use; instances zero-extend into these.
    localparam int unsigned REP_TAG_MAX = 8;
    localparam int unsigned REP_CNT_MAX = 8;

    typedef struct packed {
        logic [REP_TAG_MAX-1:0] tag;
        logic [REP_CNT_MAX-1:0] cnt;
    } rep_entry_t;

    // min(eff + 1, thr) without ever overflowing the count field.
    function automatic logic [REP_CNT_MAX-1:0] rep_sat_inc(
        input logic [REP_CNT_MAX-1:0] eff,
        input logic [REP_CNT_MAX-1:0] thr
    );
        if (eff >= thr) begin
            return thr;
        end
        return eff + REP_CNT_MAX'(1);
    endfunction

endpackage

// File: rtl/rep_entry_ram.sv
// Simple dual-port entry memory: one write port, one registered read port,
// old data returned when reading the address being written in the same cycle.
module rep_entry_ram #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 4
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rd_data;

    // Contents are deliberately not reset; an all-zero entry means "count 0".
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rep_window_detector.sv
// Counts, per fixed window of accepted samples, how many distinct values were
// repeated at least cfg_rep_thresh times; stale entries expire via generation tags.
module rep_window_detector
    import rep_pkg::*;
#(
    parameter int unsigned FIELD_SIZE  = 16,
    parameter int unsigned N_REP       = 2,
    parameter int unsigned GEN_BITS    = 2,
    parameter int unsigned WINDOW_SIZE = 32
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  valid,
    input  logic [FIELD_SIZE-1:0] field,
    input  logic                  clear,
    input  logic [N_REP-1:0]      cfg_rep_thresh,
    input  logic [FIELD_SIZE-1:0] cfg_alarm_thresh,
    output logic [FIELD_SIZE-1:0] rep_rate,
    output logic                  window_done,
    output logic                  found
);

    localparam int unsigned CNT_W = $clog2(WINDOW_SIZE);
    localparam int unsigned E_W   = GEN_BITS + N_REP;

    logic [GEN_BITS-1:0]   r_gen;
    logic [CNT_W-1:0]      r_sample_cnt;
    logic [FIELD_SIZE-1:0] r_flag_cnt;
    logic [FIELD_SIZE-1:0] r_rep_rate;
    logic                  r_found;
    logic                  r_window_done;

    logic                  r_s0_valid, r_s1_valid, r_s2_valid;
    logic                  r_s0_last,  r_s1_last,  r_s2_last;
    logic [FIELD_SIZE-1:0] r_s0_field, r_s1_field, r_s2_field;
    logic [GEN_BITS-1:0]   r_s0_gen,   r_s1_gen,   r_s2_gen;

    logic                  r_fwd_valid;
    rep_entry_t            r_fwd_entry;

    logic                  w_last;
    logic [E_W-1:0]        w_rd_data;
    logic [E_W-1:0]        w_wr_data;
    rep_entry_t            w_rd_entry;
    rep_entry_t            w_cur_entry;
    rep_entry_t            w_wr_entry;
    logic [REP_CNT_MAX-1:0] w_eff;
    logic [REP_CNT_MAX-1:0] w_thr;
    logic                  w_hit;
    logic [FIELD_SIZE-1:0] w_flag_next;

    assign w_last = (r_sample_cnt == CNT_W'(WINDOW_SIZE - 1));

    rep_entry_ram #(
        .ADDR_W (FIELD_SIZE),
        .DATA_W (E_W)
    ) u_ram (
        .i_clk     (sys_clk),
        .i_wr_en   (r_s2_valid && !clear),
        .i_wr_addr (r_s2_field),
        .i_wr_data (w_wr_data),
        .i_rd_en   (r_s1_valid),
        .i_rd_addr (r_s1_field),
        .o_rd_data (w_rd_data)
    );

    // The forwarded entry still goes through the tag check with this sample's
    // generation, so a hit across a window boundary reads as count 0.
    always_comb begin
        w_rd_entry     = '0;
        w_rd_entry.tag = REP_TAG_MAX'(w_rd_data[E_W-1:N_REP]);
        w_rd_entry.cnt = REP_CNT_MAX'(w_rd_data[N_REP-1:0]);
        w_cur_entry    = r_fwd_valid ? r_fwd_entry : w_rd_entry;
        w_eff          = (w_cur_entry.tag == REP_TAG_MAX'(r_s2_gen)) ? w_cur_entry.cnt : '0;
        w_thr          = (cfg_rep_thresh == '0) ? REP_CNT_MAX'(1) : REP_CNT_MAX'(cfg_rep_thresh);
        w_wr_entry     = '0;
        w_wr_entry.tag = REP_TAG_MAX'(r_s2_gen);
        w_wr_entry.cnt = rep_sat_inc(w_eff, w_thr);
        w_wr_data      = {w_wr_entry.tag[GEN_BITS-1:0], w_wr_entry.cnt[N_REP-1:0]};
        w_hit          = r_s2_valid && ((w_eff + REP_CNT_MAX'(1)) == w_thr);
        w_flag_next    = r_flag_cnt;
        if (w_hit && (r_flag_cnt != '1)) begin
            w_flag_next = r_flag_cnt + FIELD_SIZE'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s0_field  <= '0;
            r_s0_gen    <= '0;
            r_s0_last   <= 1'b0;
            r_s1_field  <= '0;
            r_s1_gen    <= '0;
            r_s1_last   <= 1'b0;
            r_s2_field  <= '0;
            r_s2_gen    <= '0;
            r_s2_last   <= 1'b0;
            r_fwd_entry <= '0;
        end else begin
            r_s0_field  <= field;
            r_s0_gen    <= r_gen;
            r_s0_last   <= w_last;
            r_s1_field  <= r_s0_field;
            r_s1_gen    <= r_s0_gen;
            r_s1_last   <= r_s0_last;
            r_s2_field  <= r_s1_field;
            r_s2_gen    <= r_s1_gen;
            r_s2_last   <= r_s1_last;
            r_fwd_entry <= w_wr_entry;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gen         <= '0;
            r_sample_cnt  <= '0;
            r_flag_cnt    <= '0;
            r_rep_rate    <= '0;
            r_found       <= 1'b0;
            r_window_done <= 1'b0;
            r_s0_valid    <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_fwd_valid   <= 1'b0;
        end else begin
            r_window_done <= 1'b0;
            if (clear) begin
                r_gen        <= r_gen + GEN_BITS'(1);
                r_sample_cnt <= '0;
                r_flag_cnt   <= '0;
                r_s0_valid   <= 1'b0;
                r_s1_valid   <= 1'b0;
                r_s2_valid   <= 1'b0;
                r_fwd_valid  <= 1'b0;
            end else begin
                if (valid) begin
                    r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_gen <= r_gen + GEN_BITS'(1);
                    end
                end
                r_s0_valid  <= valid;
                r_s1_valid  <= r_s0_valid;
                r_s2_valid  <= r_s1_valid;
                // S2 writes at the same edge S1 reads, so the read misses that write.
                r_fwd_valid <= r_s1_valid && r_s2_valid && (r_s1_field == r_s2_field);
                if (r_s2_valid) begin
                    if (r_s2_last) begin
                        r_flag_cnt    <= '0;
                        r_rep_rate    <= w_flag_next;
                        r_found       <= (w_flag_next >= cfg_alarm_thresh);
                        r_window_done <= 1'b1;
                    end else begin
                        r_flag_cnt <= w_flag_next;
                    end
                end
            end
        end
    end

    assign rep_rate    = r_rep_rate;
    assign found       = r_found;
    assign window_done = r_window_done;

endmodule
